lod_norm_seq: RTL and testbench
===============================

// Module: lod_norm_seq
// PURPOSE
//   Sequential leading-one detector and normaliser with valid/ready handshakes.
//   Scans an N-bit operand MSB-first, CHUNK bits per cycle, then returns:
//   - the one-hot leading-one mask
//   - the leading-one bit index
//   - the operand left-shifted so its leading one sits at bit N-1
//   Feeds the reciprocal/normalisation step of the donut fixed-point datapath.
//   Trades latency for area versus a flat combinational detector.
// PARAMETERS
//   N      16  operand width; N >= 2; N % CHUNK == 0
//   CHUNK   4  bits examined per SCAN cycle; 1 <= CHUNK <= N
//   (derived) NCH = N/CHUNK chunks; PW = $clog2(N) index width
// PORTS
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   in_valid    in   1   operand valid
//   in_ready    out  1   block can accept an operand (combinational: state==IDLE)
//   in_data     in   N   operand
//   out_valid   out  1   result valid (registered)
//   out_ready   in   1   consumer accepts result
//   out_onehot  out  N   leading-one mask, 0 if operand is zero
//   out_pos     out  PW  leading-one index (N-1 = MSB), 0 if operand is zero
//   out_norm    out  N   in_data << (N-1-out_pos), 0 if operand is zero
//   out_zero    out  1   operand was all zeros
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; shift reg, chunk count k and all
//     out_* registers cleared to 0; out_valid=0.
//   FSM states: IDLE, SCAN, DONE. in_ready=1 only in IDLE.
//   IDLE: on in_valid&&in_ready at edge E0, latch in_data into sr, set k=0,
//     go to SCAN.
//   SCAN: evaluate win = sr[N-1 -: CHUNK] at each edge.
//   - win!=0: lz = leading zeros of win; pos = N-1-(k*CHUNK+lz);
//     out_norm = sr<<lz; out_onehot = 1<<pos; out_pos = pos; out_zero = 0;
//     go to DONE.
//   - win==0 and k==NCH-1: out_zero=1; onehot/pos/norm = 0; go to DONE.
//   - otherwise: sr <<= CHUNK, k++ (stay in SCAN).
//   Latency: leading one in chunk c (0 = top chunk) -> DONE at edge E(c+1).
//     Zero operand -> DONE at E(NCH).
//   DONE: out_valid=1. Results held stable until out_valid&&out_ready, then
//     IDLE at that edge.
//   Throughput: no overlap. A new operand is accepted no earlier than the
//     edge after the result transfer.
//   out_* registers update only on the SCAN->DONE (or fast-zero) transition.
//     They keep their last values in IDLE/SCAN; out_valid is the only
//     qualifier.
//   in_data is sampled only at the accept edge; changes afterwards are ignored.
//   Reset mid-SCAN or mid-DONE: operand discarded; no partial result emitted.
//   CHUNK==N: every non-zero operand completes in a single SCAN cycle.
// CONFIGURATION
//   LOD_FASTZERO_EN defined:
//   - IDLE checks in_data==0 at the accept edge.
//   - If zero, go directly to DONE at E0 with out_zero=1 and other outputs 0.
//     out_valid is visible in the cycle after the accept.
//   - Non-zero operands are unaffected.
//   LOD_FASTZERO_EN undefined: zero operands take the full NCH SCAN cycles.
// TESTING (N=16, CHUNK=4)
//   1 in 0x8000 -> DONE at E1: pos 15, onehot 0x8000, norm 0x8000, zero 0.
//   2 in 0x0B30 -> DONE at E2: pos 11, onehot 0x0800, norm 0xB300.
//     in 0x0001 -> DONE at E4: pos 0, norm 0x8000.
//   3 in 0x0000 -> zero 1, pos/onehot/norm 0. DONE at E4 without the macro,
//     at E0 with LOD_FASTZERO_EN.
//   4 out_ready low 5 cycles in DONE -> out_valid and all out_* stable,
//     in_ready 0. Raise out_ready -> IDLE next edge, in_ready 1.
//   5 rst_n pulsed low mid-SCAN on 0x0001 -> out_valid 0 and out_* 0 at once.
//     Next operand 0x4000 -> pos 14 at E1.
//   6 2000 random operands, random in_valid/out_ready gaps -> every result
//     matches the model (pos=floor(log2 x), norm=x<<(15-pos)); no drops or dups.

Source files
------------

// File: rtl/lod_norm_seq.sv
// Sequential leading-one detector / normaliser: scans the operand MSB-first, CHUNK bits per cycle.
// Optional macro LOD_FASTZERO_EN: zero operands go straight from IDLE to DONE at the accept edge.
module lod_norm_seq #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_onehot,
  output logic [$clog2(N)-1:0] out_pos,
  output logic [N-1:0]         out_norm,
  output logic                 out_zero,
  output logic [1:0]           dbg_state_o
);

  localparam int NCH = N / CHUNK;
  localparam int PW  = $clog2(N);
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [N-1:0]   norm_q, norm_d;
  logic           zero_q, zero_d;

  logic [CHUNK-1:0] win;
  logic [PW-1:0]    lz;
  logic [PW-1:0]    hit_pos;
  logic             last_chunk;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready depends only on state, out_valid is a state decode
  // and the out_* payload is held stable from DONE entry until its transfer.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_onehot  = onehot_q;
  assign out_pos     = pos_q;
  assign out_norm    = norm_q;
  assign out_zero    = zero_q;
  assign dbg_state_o = state_q;

  // The window is always the top CHUNK bits; the shift register walks lower
  // chunks up into it, so the leading-zero count of the window plus the
  // bits already shifted out gives the distance from the MSB.
  always_comb begin
    win = sr_q[N-1 -: CHUNK];
    lz  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (win[i]) lz = PW'(CHUNK - 1 - i);
    end
    hit_pos    = PW'(N - 1 - (int'(k_q) * CHUNK + int'(lz)));
    last_chunk = (k_q == KW'(NCH - 1));
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    k_d      = k_q;
    onehot_d = onehot_q;
    pos_d    = pos_q;
    norm_d   = norm_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef LOD_FASTZERO_EN
          if (in_data == '0) begin
            state_d  = DONE;
            zero_d   = 1'b1;
            onehot_d = '0;
            pos_d    = '0;
            norm_d   = '0;
          end else begin
            sr_d    = in_data;
            k_d     = '0;
            state_d = SCAN;
          end
`else
          sr_d    = in_data;
          k_d     = '0;
          state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (win != '0) begin
          norm_d   = sr_q << lz;
          onehot_d = N'(1) << hit_pos;
          pos_d    = hit_pos;
          zero_d   = 1'b0;
          state_d  = DONE;
        end else if (last_chunk) begin
          norm_d   = '0;
          onehot_d = '0;
          pos_d    = '0;
          zero_d   = 1'b1;
          state_d  = DONE;
        end else begin
          sr_d = sr_q << CHUNK;
          k_d  = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      k_q      <= '0;
      onehot_q <= '0;
      pos_q    <= '0;
      norm_q   <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      k_q      <= k_d;
      onehot_q <= onehot_d;
      pos_q    <= pos_d;
      norm_q   <= norm_d;
      zero_q   <= zero_d;
    end
  end

  // A stalled result must not move while the consumer is not ready.
  a_hold_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_norm) &&
      $stable(out_pos) && $stable(out_onehot) && $stable(out_zero)));

  a_onehot_shape: assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid |-> (out_zero ? (out_onehot == '0) : $onehot(out_onehot)));

endmodule

// File: tb/tb_lod_norm_seq.sv
// Self-checking bench for lod_norm_seq (N=16, CHUNK=4): directed cases, stall, reset and random traffic.
module tb_lod_norm_seq;

  localparam int N     = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = N / CHUNK;
  localparam int W     = 1 + 4 + N + N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_onehot;
  logic [3:0]    out_pos;
  logic [N-1:0]  out_norm;
  logic          out_zero;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  lod_norm_seq #(.N(N), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_pos    (out_pos),
    .out_norm   (out_norm),
    .out_zero   (out_zero),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: {zero, pos, onehot, norm}
  function automatic logic [W-1:0] model(input logic [N-1:0] x);
    int p;
    logic [N-1:0] one, nrm;
    p = -1;
    for (int i = 0; i < N; i++) if (x[i]) p = i;
    if (p < 0) return {1'b1, 4'd0, 16'd0, 16'd0};
    one = 16'd1 << p;
    nrm = x << (N - 1 - p);
    return {1'b0, 4'(p), one, nrm};
  endfunction

  // edges after the accept edge until DONE
  function automatic int model_lat(input logic [N-1:0] x);
    int p;
    p = -1;
    for (int i = 0; i < N; i++) if (x[i]) p = i;
`ifdef LOD_FASTZERO_EN
    if (p < 0) return 0;
`else
    if (p < 0) return NCH;
`endif
    return (N - 1 - p) / CHUNK + 1;
  endfunction

  function automatic logic [W-1:0] observed();
    return {out_zero, out_pos, out_onehot, out_norm};
  endfunction

  // driver tasks
  task automatic start_op(input logic [N-1:0] x, output bit ok);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic wait_result(output int lat, output bit ok);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_cmp++;
    if (observed() !== '0) begin n_err++; $display("FAIL reset_outs: got %h want 0", observed()); end
    n_cmp++;
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [N-1:0] vals [5];
    bit ok_a, ok_r;
    int lat;
    vals = '{16'h8000, 16'h0B30, 16'h0001, 16'h0000, 16'h00F0};
    foreach (vals[i]) begin
      start_op(vals[i], ok_a);
      wait_result(lat, ok_r);
      n_cmp++;
      if (!(ok_a && ok_r)) begin n_err++; $display("FAIL dir_timeout[%h]: accept %b result %b want 1 1", vals[i], ok_a, ok_r); end
      n_cmp++;
      if (lat != model_lat(vals[i])) begin n_err++; $display("FAIL dir_latency[%h]: got %0d want %0d", vals[i], lat, model_lat(vals[i])); end
      n_cmp++;
      if (observed() !== model(vals[i])) begin n_err++; $display("FAIL dir_result[%h]: got %h want %h", vals[i], observed(), model(vals[i])); end
      release_out();
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL dir_release[%h]: got ready %b valid %b want 1 0", vals[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    bit ok_a, ok_r;
    int lat;
    logic [W-1:0] exp;
    exp = model(16'h0B30);
    start_op(16'h0B30, ok_a);
    wait_result(lat, ok_r);
    n_cmp++;
    if (!(ok_a && ok_r)) begin n_err++; $display("FAIL hold_timeout: accept %b result %b want 1 1", ok_a, ok_r); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got valid %b ready %b outs %h want 1 0 %h", c, out_valid, in_ready, observed(), exp);
      end
      @(negedge clk);
    end
    release_out();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_release: got ready %b valid %b want 1 0", in_ready, out_valid);
    end
    n_cmp++;
    if (observed() !== exp) begin n_err++; $display("FAIL hold_idle_keep: got %h want %h", observed(), exp); end
  endtask

  task automatic test_reset_mid_scan();
    bit ok_a, ok_r;
    int lat;
    start_op(16'h0001, ok_a);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || observed() !== '0) begin
      n_err++; $display("FAIL rst_mid_scan: got valid %b outs %h want 0 0", out_valid, observed());
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h4000, ok_a);
    wait_result(lat, ok_r);
    n_cmp++;
    if (!(ok_a && ok_r) || lat != 1) begin
      n_err++; $display("FAIL rst_next_latency: got ok %b%b lat %0d want 11 1", ok_a, ok_r, lat);
    end
    n_cmp++;
    if (out_pos !== 4'd14 || observed() !== model(16'h4000)) begin
      n_err++; $display("FAIL rst_next_result: got %h want %h", observed(), model(16'h4000));
    end
    release_out();
  endtask

  task automatic test_random();
    bit ok_a, ok_r;
    int lat;
    logic [N-1:0] x;
    logic [W-1:0] exp;
    for (int n = 0; n < 2000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      x = 16'($urandom) >> $urandom_range(0, 16);
      exp_q.push_back(model(x));
      start_op(x, ok_a);
      wait_result(lat, ok_r);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!(ok_a && ok_r)) begin
        n_err++; $display("FAIL rnd_timeout[%0d] x=%h: accept %b result %b want 1 1", n, x, ok_a, ok_r);
        return;
      end
      n_cmp++;
      if (lat != model_lat(x)) begin n_err++; $display("FAIL rnd_latency[%0d] x=%h: got %0d want %0d", n, x, lat, model_lat(x)); end
      n_cmp++;
      if (observed() !== exp) begin n_err++; $display("FAIL rnd_result[%0d] x=%h: got %h want %h", n, x, observed(), exp); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_out();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_queue: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
